// File: rtl/npc_ifu_if.sv
// Handshake bundle between the fetch unit, instruction memory and the core.
// master = fetch unit side, slave = memory/core environment side.
interface npc_ifu_if;
  // Fetch redirect from the core
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // Instruction memory request channel (valid/ready)
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  // Instruction memory response channel (valid only)
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  // Instruction delivery toward the core (valid/ready)
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  inst_ready,
    output imem_req_valid, imem_req_addr,
    output inst_valid, inst, inst_pc, inst_fault
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output inst_ready,
    input  imem_req_valid, imem_req_addr,
    input  inst_valid, inst, inst_pc, inst_fault
  );
endinterface

// File: rtl/npc_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one word read at a time,
// queues returned words and hands {inst, pc, fault} to the core.
module npc_ifu #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  npc_ifu_if.master  bus
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t             state;
  logic [31:0]        fetch_pc;
  logic [31:0]        req_addr;
  logic               req_valid;
  logic               stale;
  logic               halted;
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [CNT_W-1:0]   count;

  logic [31:0]        q_inst  [QUEUE_DEPTH];
  logic [31:0]        q_pc    [QUEUE_DEPTH];
  logic               q_fault [QUEUE_DEPTH];

  logic               empty;
  logic               has_space;
  logic               deq;
  logic               rsp_enq;
  logic               mis_enq;
  logic               enq;
  logic [31:0]        enq_inst;
  logic [31:0]        enq_pc;
  logic               enq_fault;

  // Queue status, enqueue sources and head outputs; redirect suppresses both
  // enqueue and delivery in its cycle because the queue is being flushed.
  always_comb begin
    empty     = (count == '0);
    has_space = (count < CNT_W'(QUEUE_DEPTH));
    rsp_enq   = (state == WAIT) && bus.imem_rsp_valid && !stale && !bus.redirect_valid;
    mis_enq   = (state == IDLE) && !halted && has_space &&
                (fetch_pc[1:0] != 2'b00) && !bus.redirect_valid;
    enq       = rsp_enq || mis_enq;
    enq_inst  = '0;
    enq_pc    = fetch_pc;
    enq_fault = 1'b1;
    if (rsp_enq) begin
      enq_inst  = bus.imem_rsp_err ? 32'h0 : bus.imem_rsp_data;
      enq_pc    = req_addr;
      enq_fault = bus.imem_rsp_err;
    end
    bus.inst_valid     = !empty && !bus.redirect_valid;
    deq                = bus.inst_valid && bus.inst_ready;
    bus.inst           = empty ? 32'h0 : q_inst[rptr];
    bus.inst_pc        = empty ? 32'h0 : q_pc[rptr];
    bus.inst_fault     = empty ? 1'b0  : q_fault[rptr];
    bus.imem_req_valid = req_valid;
    bus.imem_req_addr  = req_addr;
  end

  // Fetch FSM, PC tracking and queue pointers; redirect overrides every other event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      req_addr  <= RESET_PC;
      req_valid <= 1'b0;
      stale     <= 1'b0;
      halted    <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
    end else if (bus.redirect_valid) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      halted   <= 1'b0;
      fetch_pc <= bus.redirect_pc;
      unique case (state)
        REQ: begin
          // The in-flight request must still complete; its data is discarded.
          stale <= 1'b1;
          if (bus.imem_req_ready) begin
            state     <= WAIT;
            req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            state <= IDLE;
            stale <= 1'b0;
          end else begin
            stale <= 1'b1;
          end
        end
        default: ;
      endcase
    end else begin
      if (enq) wptr <= wptr + PTR_W'(1);
      if (deq) rptr <= rptr + PTR_W'(1);
      unique case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      unique case (state)
        IDLE: begin
          if (!halted && has_space) begin
            if (fetch_pc[1:0] != 2'b00) begin
              halted <= 1'b1;
            end else begin
              state     <= REQ;
              req_addr  <= fetch_pc;
              req_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus.imem_req_ready) begin
            state     <= WAIT;
            req_valid <= 1'b0;
            // A stale request keeps the redirect target as the next fetch PC.
            if (!stale) fetch_pc <= req_addr + 32'd4;
          end
        end
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            state <= IDLE;
            if (stale)                  stale  <= 1'b0;
            else if (bus.imem_rsp_err)  halted <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Queue storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_inst[wptr]  <= enq_inst;
      q_pc[wptr]    <= enq_pc;
      q_fault[wptr] <= enq_fault;
    end
  end

endmodule

// File: tb/tb_npc_ifu.sv
// Bench for npc_ifu: memory model with configurable response delay and
// request grants, expected requests and instructions held in queues.
module tb_npc_ifu;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } ent_t;

  logic clk;
  logic rst;
  npc_ifu_if bus ();

  npc_ifu #(.RESET_PC(32'h8000_0000), .QUEUE_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_err;
  logic [31:0] exp_addr_q [$];
  ent_t        exp_ent_q  [$];

  int          rsp_delay;
  int          grants;
  bit          pend;
  int          pcnt;
  logic [31:0] paddr;
  logic [31:0] rsp_addr;
  bit          err_en;
  logic [31:0] err_addr;
  bit          hs_seen;
  logic [31:0] hs_addr;
  int          n_req;
  int          cyc;
  bit          seen_valid;
  int          first_valid_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic push_req(input logic [31:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic push_ent(input logic [31:0] i, input logic [31:0] p, input logic f);
    ent_t e;
    e.inst = i; e.pc = p; e.fault = f;
    exp_ent_q.push_back(e);
  endtask

  task automatic push_ok(input logic [31:0] a);
    push_req(a);
    push_ent(mdata(a), a, 1'b0);
  endtask

  // One clock cycle: observe at negedge, then drive memory side after posedge.
  task automatic tick();
    ent_t e;
    hs_seen = 1'b0;
    @(negedge clk);
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      hs_seen = 1'b1;
      hs_addr = bus.imem_req_addr;
      n_req++;
      chk("req_expected", 32'(exp_addr_q.size() != 0), 32'd1);
      if (exp_addr_q.size() != 0) chk("req_addr", bus.imem_req_addr, exp_addr_q.pop_front());
    end
    if (bus.inst_valid && !seen_valid) begin
      seen_valid      = 1'b1;
      first_valid_cyc = cyc;
    end
    if (bus.inst_valid && bus.inst_ready) begin
      chk("inst_expected", 32'(exp_ent_q.size() != 0), 32'd1);
      if (exp_ent_q.size() != 0) begin
        e = exp_ent_q.pop_front();
        chk("inst_pc", bus.inst_pc, e.pc);
        chk("inst_word", bus.inst, e.inst);
        chk("inst_fault", 32'(bus.inst_fault), 32'(e.fault));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.imem_rsp_err   = 1'b0;
    if (hs_seen) begin
      pend  = 1'b1;
      pcnt  = rsp_delay;
      paddr = hs_addr;
      if (grants > 0) grants--;
    end
    if (pend) begin
      pcnt--;
      if (pcnt == 0) begin
        pend               = 1'b0;
        rsp_addr           = paddr;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mdata(paddr);
        bus.imem_rsp_err   = err_en && (paddr == err_addr);
      end
    end
    bus.imem_req_ready = (grants > 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input string tag, input int limit);
    int n;
    n = 0;
    while ((exp_addr_q.size() != 0 || exp_ent_q.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    chk({tag, "_drain"}, 32'(n < limit), 32'd1);
  endtask

  task automatic set_grants(input int g);
    grants = g;
    bus.imem_req_ready = (g > 0);
  endtask

  // Reset DUT and memory model together; reset acts asynchronously.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    pend = 1'b0; pcnt = 0; err_en = 1'b0; err_addr = 32'h0;
    set_grants(0);
    rsp_delay = 1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.imem_rsp_err   = 1'b0;
    bus.inst_ready     = 1'b0;
    exp_addr_q.delete();
    exp_ent_q.delete();
    #1;
    chk({tag, "_rst_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
    chk({tag, "_rst_req_addr"},  bus.imem_req_addr, 32'h8000_0000);
    chk({tag, "_rst_inst_valid"}, 32'(bus.inst_valid), 32'd0);
    chk({tag, "_rst_inst"},      bus.inst, 32'h0);
    chk({tag, "_rst_inst_pc"},   bus.inst_pc, 32'h0);
    chk({tag, "_rst_fault"},     32'(bus.inst_fault), 32'd0);
    run(2);
    n_req = 0;
    seen_valid = 1'b0;
  endtask

  task automatic release_rst();
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_chk = 0; n_err = 0; n_req = 0; cyc = 0; hs_seen = 1'b0; hs_addr = 32'h0;
    rsp_addr = 32'h0; paddr = 32'h0; seen_valid = 1'b0; first_valid_cyc = 0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: sequential fetch with zero-wait memory, first-instruction latency.
    do_reset("t1");
    set_grants(3);
    bus.inst_ready = 1'b1;
    push_ok(32'h8000_0000); push_ok(32'h8000_0004); push_ok(32'h8000_0008);
    release_rst();
    drain("t1", 40);
    chk("t1_latency", 32'(first_valid_cyc), 32'd3);
    run(2);
    chk("t1_stall_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t1_stall_addr", bus.imem_req_addr, 32'h8000_000C);

    // 2: backpressure fills the queue and stops fetching; reset lands mid-request.
    do_reset("t2");
    set_grants(3);
    push_ok(32'h8000_0000); push_ok(32'h8000_0004); push_ok(32'h8000_0008);
    release_rst();
    run(15);
    chk("t2_req_count", 32'(n_req), 32'd2);
    chk("t2_req_idle", 32'(bus.imem_req_valid), 32'd0);
    chk("t2_head_valid", 32'(bus.inst_valid), 32'd1);
    chk("t2_head_pc", bus.inst_pc, 32'h8000_0000);
    bus.inst_ready = 1'b1;
    drain("t2", 40);

    // 3: redirect while waiting on a late response.
    do_reset("t3");
    set_grants(2);
    rsp_delay = 3;
    bus.inst_ready = 1'b1;
    push_req(32'h8000_0000);
    push_ok(32'h8000_0100);
    release_rst();
    n = 0;
    do begin tick(); n++; end while (!hs_seen && n < 20);
    chk("t3_wait_hs", 32'(n < 20), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    tick();
    bus.redirect_valid = 1'b0;
    drain("t3", 40);

    // 4: redirect in the same cycle as a response, with one entry already queued.
    do_reset("t4");
    set_grants(3);
    push_req(32'h8000_0000);
    push_req(32'h8000_0004);
    push_ok(32'h8000_0200);
    release_rst();
    n = 0;
    do begin tick(); n++; end
    while (!(bus.imem_rsp_valid && rsp_addr == 32'h8000_0004) && n < 30);
    chk("t4_wait_rsp", 32'(n < 30), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0200;
    #1;
    chk("t4_valid_in_redirect", 32'(bus.inst_valid), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t4_flushed", 32'(bus.inst_valid), 32'd0);
    bus.inst_ready = 1'b1;
    drain("t4", 40);

    // 5: access fault halts fetch until a redirect.
    do_reset("t5");
    set_grants(10);
    err_en = 1'b1;
    err_addr = 32'h8000_0008;
    bus.inst_ready = 1'b1;
    push_ok(32'h8000_0000); push_ok(32'h8000_0004);
    push_req(32'h8000_0008);
    push_ent(32'h0, 32'h8000_0008, 1'b1);
    release_rst();
    drain("t5", 40);
    run(10);
    chk("t5_req_count", 32'(n_req), 32'd3);
    chk("t5_halt_req", 32'(bus.imem_req_valid), 32'd0);
    chk("t5_halt_inst", 32'(bus.inst_valid), 32'd0);
    set_grants(1);
    push_ok(32'h8000_0000);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0000;
    tick();
    bus.redirect_valid = 1'b0;
    drain("t5r", 40);

    // 6: misaligned redirect faults without a request; then PC wrap at the top.
    do_reset("t6");
    set_grants(5);
    bus.inst_ready = 1'b1;
    push_ent(32'h0, 32'h8000_0102, 1'b1);
    release_rst();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0102;
    tick();
    bus.redirect_valid = 1'b0;
    drain("t6", 40);
    run(10);
    chk("t6_no_req", 32'(n_req), 32'd0);
    chk("t6_req_idle", 32'(bus.imem_req_valid), 32'd0);
    set_grants(2);
    push_ok(32'hFFFF_FFFC);
    push_ok(32'h0000_0000);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    drain("t6w", 40);
    run(2);
    chk("t6w_next_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t6w_next_addr", bus.imem_req_addr, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
